// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types and helpers for the pipeline hazard controller: in-flight slot
// record, forwarding-select constants and the "slot writes register" predicate.
package pipe_hazard_pkg;

    // Slot register fields are sized for the widest supported REG_AW (<= 8).
    localparam int REG_AW_MAX = 8;
    localparam int FWD_RF     = 0;

    typedef logic [REG_AW_MAX-1:0] reg_addr_t;

    typedef struct packed {
        logic      valid;
        reg_addr_t rs;
        reg_addr_t rt;
        logic      use_rs;
        logic      use_rt;
        reg_addr_t rw;
        logic      regwr;
        logic      load;
    } slot_t;

    function automatic int fwd_sel_w(input int depth);
        return $clog2(depth + 1);
    endfunction

    function automatic logic slot_writes(input slot_t s, input reg_addr_t r);
        return s.valid && s.regwr && (s.rw == r) && (r != '0);
    endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// ID-stage hazard bus: instruction register usage in, pipeline enables,
// flush and Ex-stage forwarding selects out.
interface pipe_hazard_ctrl_if import pipe_hazard_pkg::*; #(
    parameter int REG_AW = 5,
    parameter int DEPTH  = 3,
    parameter int CNT_W  = 16
);
    localparam int SEL_W = fwd_sel_w(DEPTH);

    logic              id_valid;
    logic [REG_AW-1:0] id_rs;
    logic [REG_AW-1:0] id_rt;
    logic              id_use_rs;
    logic              id_use_rt;
    logic [REG_AW-1:0] id_rw;
    logic              id_regwr;
    logic              id_load;
    logic              br_taken;
    logic              pc_en;
    logic              ifid_en;
    logic              flush;
    logic              stall;
    logic [SEL_W-1:0]  fwd_a;
    logic [SEL_W-1:0]  fwd_b;
    logic [CNT_W-1:0]  stall_cnt;
    logic [CNT_W-1:0]  flush_cnt;

    modport master (
        output id_valid, id_rs, id_rt, id_use_rs, id_use_rt, id_rw, id_regwr, id_load, br_taken,
        input  pc_en, ifid_en, flush, stall, fwd_a, fwd_b, stall_cnt, flush_cnt
    );

    modport slave (
        input  id_valid, id_rs, id_rt, id_use_rs, id_use_rt, id_rw, id_regwr, id_load, br_taken,
        output pc_en, ifid_en, flush, stall, fwd_a, fwd_b, stall_cnt, flush_cnt
    );

endinterface

// File: rtl/pipe_hazard_ctrl_fwd_sel.sv
// Priority match of one Ex source register against the older slots s[2..DEPTH];
// returns the index of the youngest producer, or FWD_RF when none matches.
module hazard_fwd_sel import pipe_hazard_pkg::*; #(
    parameter int DEPTH = 3,
    parameter int SEL_W = 2
) (
    input  slot_t [DEPTH:2] older,
    input  reg_addr_t       src,
    input  logic            en,
    output logic [SEL_W-1:0] sel
);

    always_comb begin
        sel = SEL_W'(FWD_RF);
        // Scan oldest to youngest so the smallest matching index is the last write.
        for (int k = DEPTH; k >= 2; k--) begin
            if (en && slot_writes(older[k], src)) begin
                sel = SEL_W'(k);
            end
        end
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Scoreboard-based hazard controller: load-use stall, taken-branch flush and
// Ex-stage forwarding. Define HAZ_PERF_CNT_EN to build the stall/flush counters.
module pipe_hazard_ctrl import pipe_hazard_pkg::*; #(
    parameter int REG_AW     = 5,
    parameter int DEPTH      = 3,
    parameter int LOAD_STAGE = 2,
    parameter int BR_STAGE   = 2,
    parameter int CNT_W      = 16
) (
    input logic                Clk,
    input logic                Rst,
    pipe_hazard_ctrl_if.slave  bus
);

    localparam int    SEL_W  = fwd_sel_w(DEPTH);
    localparam slot_t BUBBLE = '0;

    slot_t [DEPTH:1]  slots_q;
    slot_t            id_slot;
    logic             load_hz;
    logic             flush;
    logic             stall;
    logic [SEL_W-1:0] fwd_a;
    logic [SEL_W-1:0] fwd_b;
    logic             unused_tail;

    always_comb begin
        id_slot                   = '0;
        id_slot.valid             = bus.id_valid;
        id_slot.rs[REG_AW-1:0]    = bus.id_rs;
        id_slot.rt[REG_AW-1:0]    = bus.id_rt;
        id_slot.use_rs            = bus.id_use_rs;
        id_slot.use_rt            = bus.id_use_rt;
        id_slot.rw[REG_AW-1:0]    = bus.id_rw;
        id_slot.regwr             = bus.id_regwr;
        id_slot.load              = bus.id_load;
    end

    // A load whose data is not yet available sits in s[1..LOAD_STAGE-1].
    always_comb begin
        load_hz = 1'b0;
        for (int k = 1; k <= LOAD_STAGE - 1; k++) begin
            if (slots_q[k].load &&
                ((id_slot.use_rs && slot_writes(slots_q[k], id_slot.rs)) ||
                 (id_slot.use_rt && slot_writes(slots_q[k], id_slot.rt)))) begin
                load_hz = 1'b1;
            end
        end
    end

    assign flush       = bus.br_taken & slots_q[BR_STAGE].valid;
    assign stall       = bus.id_valid & load_hz & ~flush;
    assign bus.flush   = flush;
    assign bus.stall   = stall;
    assign bus.pc_en   = ~stall;
    assign bus.ifid_en = ~stall;

    always_ff @(posedge Clk) begin
        if (Rst) begin
            slots_q <= '0;
        end else begin
            // NOTE: non-blocking so every slot takes its neighbour's pre-edge value, independent of loop order.
            for (int k = DEPTH; k >= 2; k--) begin
                slots_q[k] <= (flush && k <= BR_STAGE) ? BUBBLE : slots_q[k-1];
            end
            slots_q[1] <= (!bus.id_valid || stall || flush) ? BUBBLE : id_slot;
        end
    end

    hazard_fwd_sel #(.DEPTH(DEPTH), .SEL_W(SEL_W)) u_fwd_a (
        .older (slots_q[DEPTH:2]),
        .src   (slots_q[1].rs),
        .en    (slots_q[1].valid & slots_q[1].use_rs),
        .sel   (fwd_a)
    );

    hazard_fwd_sel #(.DEPTH(DEPTH), .SEL_W(SEL_W)) u_fwd_b (
        .older (slots_q[DEPTH:2]),
        .src   (slots_q[1].rt),
        .en    (slots_q[1].valid & slots_q[1].use_rt),
        .sel   (fwd_b)
    );

    assign bus.fwd_a = fwd_a;
    assign bus.fwd_b = fwd_b;

    // The oldest slot only serves as a forwarding source; its source fields retire unread.
    assign unused_tail = ^{slots_q[DEPTH].rs, slots_q[DEPTH].rt, slots_q[DEPTH].use_rs,
                           slots_q[DEPTH].use_rt, slots_q[DEPTH].load};

`ifdef HAZ_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cnt_q;
    logic [CNT_W-1:0] flush_cnt_q;

    always_ff @(posedge Clk) begin
        if (Rst) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (stall && !(&stall_cnt_q)) stall_cnt_q <= stall_cnt_q + CNT_W'(1);
            if (flush && !(&flush_cnt_q)) flush_cnt_q <= flush_cnt_q + CNT_W'(1);
        end
    end

    assign bus.stall_cnt = stall_cnt_q;
    assign bus.flush_cnt = flush_cnt_q;
`else
    assign bus.stall_cnt = {CNT_W{1'b0}};
    assign bus.flush_cnt = {CNT_W{1'b0}};
`endif

endmodule
